// File: rtl/placement_cost_eval.sv
// Post-placement cost evaluator: walks the edge list, fetches endpoint positions and
// accumulates Manhattan / 1-hop wirelength, longest edge and placement error flags.
module placement_cost_eval #(
    parameter int unsigned N_EDGE = 142,
    parameter int unsigned GRID_N = 12,
    parameter int unsigned DW     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 ea_re,
    output logic                 eb_re,
    output logic [DW-1:0]        ea_addr,
    output logic [DW-1:0]        eb_addr,
    input  logic [DW-1:0]        ea_data,
    input  logic [DW-1:0]        eb_data,
    output logic                 px_re,
    output logic                 py_re,
    output logic [DW-1:0]        px_addr,
    output logic [DW-1:0]        py_addr,
    input  logic signed [DW-1:0] px_data,
    input  logic signed [DW-1:0] py_data,
    output logic signed [DW-1:0] sum,
    output logic signed [DW-1:0] sum_1hop,
    output logic [DW-1:0]        max_len,
    output logic                 err_unplaced,
    output logic                 err_range
);

    localparam logic signed [DW-1:0] NEG_ONE  = '1;
    localparam logic signed [DW-1:0] GRID_LIM = DW'(GRID_N);
    localparam logic [DW-1:0]        LAST_CNT = DW'(N_EDGE);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_E, S_CAP_E, S_RD_A, S_CAP_A, S_RD_B, S_CAP_B,
        S_DIFF, S_ABS, S_ACC, S_DONE
    } state_t;

    state_t                state;
    logic [DW-1:0]         idx;
    logic [DW-1:0]         node_b;
    logic signed [DW-1:0]  ax, ay, bx, by;
    logic [DW-1:0]         dx, dy;
    logic                  edge_unpl, edge_rng;
    logic [DW-1:0]         idx_next, len, hop;

    function automatic logic is_unpl(input logic signed [DW-1:0] c);
        return c == NEG_ONE;
    endfunction

    function automatic logic is_rng(input logic signed [DW-1:0] c);
        return (c >= GRID_LIM) || (c < NEG_ONE);
    endfunction

    // Per-edge contributions, valid while in ACC (dx/dy already absolute)
    always_comb begin
        idx_next = idx + DW'(1);
        len      = dx + dy;
        hop      = (dx >> 1) + DW'(dx[0]) + (dy >> 1) + DW'(dy[0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            ea_re        <= 1'b0;
            eb_re        <= 1'b0;
            px_re        <= 1'b0;
            py_re        <= 1'b0;
            ea_addr      <= '0;
            eb_addr      <= '0;
            px_addr      <= '0;
            py_addr      <= '0;
            sum          <= '0;
            sum_1hop     <= '0;
            max_len      <= '0;
            err_unplaced <= 1'b0;
            err_range    <= 1'b0;
            idx          <= '0;
            node_b       <= '0;
            ax           <= '0;
            ay           <= '0;
            bx           <= '0;
            by           <= '0;
            dx           <= '0;
            dy           <= '0;
            edge_unpl    <= 1'b0;
            edge_rng     <= 1'b0;
        end else begin
            // Read enables are single-cycle strobes raised on entry to an RD state
            ea_re <= 1'b0;
            eb_re <= 1'b0;
            px_re <= 1'b0;
            py_re <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sum          <= '0;
                        sum_1hop     <= '0;
                        max_len      <= '0;
                        err_unplaced <= 1'b0;
                        err_range    <= 1'b0;
                        idx          <= '0;
                        ea_addr      <= '0;
                        eb_addr      <= '0;
                        ea_re        <= 1'b1;
                        eb_re        <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_RD_E;
                    end
                end
                S_RD_E: state <= S_CAP_E;
                S_CAP_E: begin
                    node_b  <= eb_data;
                    px_addr <= ea_data;
                    py_addr <= ea_data;
                    px_re   <= 1'b1;
                    py_re   <= 1'b1;
                    state   <= S_RD_A;
                end
                S_RD_A: state <= S_CAP_A;
                S_CAP_A: begin
                    ax      <= px_data;
                    ay      <= py_data;
                    px_addr <= node_b;
                    py_addr <= node_b;
                    px_re   <= 1'b1;
                    py_re   <= 1'b1;
                    state   <= S_RD_B;
                end
                S_RD_B: state <= S_CAP_B;
                S_CAP_B: begin
                    bx    <= px_data;
                    by    <= py_data;
                    state <= S_DIFF;
                end
                S_DIFF: begin
                    dx        <= ax - bx;
                    dy        <= ay - by;
                    edge_unpl <= is_unpl(ax) | is_unpl(ay) | is_unpl(bx) | is_unpl(by);
                    edge_rng  <= is_rng(ax) | is_rng(ay) | is_rng(bx) | is_rng(by);
                    state     <= S_ABS;
                end
                S_ABS: begin
                    dx    <= dx[DW-1] ? -dx : dx;
                    dy    <= dy[DW-1] ? -dy : dy;
                    state <= S_ACC;
                end
                S_ACC: begin
                    if (edge_unpl || edge_rng) begin
                        err_unplaced <= err_unplaced | edge_unpl;
                        err_range    <= err_range | edge_rng;
                    end else begin
                        sum      <= sum + len - DW'(1);
                        sum_1hop <= sum_1hop + hop - DW'(1);
                        if (len > max_len) max_len <= len;
                    end
                    idx <= idx_next;
                    if (idx_next == LAST_CNT) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        ea_addr <= idx_next;
                        eb_addr <= idx_next;
                        ea_re   <= 1'b1;
                        eb_re   <= 1'b1;
                        state   <= S_RD_E;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_placement_cost_eval.sv
// Self-checking bench for placement_cost_eval: behavioural memories, directed
// scenarios with hand-computed results, and randomized runs against a reference model.
module tb_placement_cost_eval;

    localparam int N_E   = 142;
    localparam int N_NODE = 16;
    localparam int DONE_CYC = 9 * N_E + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, ea_re, eb_re, px_re, py_re;
    logic [31:0] ea_addr, eb_addr, px_addr, py_addr;
    logic [31:0] ea_data = '0, eb_data = '0;
    logic signed [31:0] px_data = '0, py_data = '0;
    logic signed [31:0] sum, sum_1hop;
    logic [31:0] max_len;
    logic err_unplaced, err_range;

    int ea_mem [N_E];
    int eb_mem [N_E];
    int px_mem [N_NODE];
    int py_mem [N_NODE];

    int n_checks = 0;
    int n_fail   = 0;

    int re_viol = 0, ea_pulses = 0, px_pulses = 0, done_pulses = 0;
    logic prev_ea = 1'b0, prev_eb = 1'b0, prev_px = 1'b0, prev_py = 1'b0;

    logic [231:0] all_outs;
    logic [97:0]  res_vec;
    assign all_outs = {busy, done, ea_re, eb_re, px_re, py_re, ea_addr, eb_addr, px_addr, py_addr,
                       sum, sum_1hop, max_len, err_unplaced, err_range};
    assign res_vec  = {sum, sum_1hop, max_len, err_unplaced, err_range};

    placement_cost_eval #(.N_EDGE(N_E), .GRID_N(12), .DW(32)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ea_re(ea_re), .eb_re(eb_re), .ea_addr(ea_addr), .eb_addr(eb_addr),
        .ea_data(ea_data), .eb_data(eb_data),
        .px_re(px_re), .py_re(py_re), .px_addr(px_addr), .py_addr(py_addr),
        .px_data(px_data), .py_data(py_data),
        .sum(sum), .sum_1hop(sum_1hop), .max_len(max_len),
        .err_unplaced(err_unplaced), .err_range(err_range)
    );

    always #5 clk = ~clk;

    // One-cycle registered-read memories
    always @(posedge clk) begin
        if (ea_re) ea_data <= ea_mem[ea_addr[7:0]];
        if (eb_re) eb_data <= eb_mem[eb_addr[7:0]];
        if (px_re) px_data <= px_mem[px_addr[3:0]];
        if (py_re) py_data <= py_mem[py_addr[3:0]];
    end

    // Strobe monitor: read enables must never stay high two cycles in a row
    always @(posedge clk) begin
        prev_ea <= ea_re;
        prev_eb <= eb_re;
        prev_px <= px_re;
        prev_py <= py_re;
        if ((ea_re && prev_ea) || (eb_re && prev_eb) || (px_re && prev_px) || (py_re && prev_py))
            re_viol <= re_viol + 1;
        if (ea_re) ea_pulses <= ea_pulses + 1;
        if (px_re) px_pulses <= px_pulses + 1;
        if (done) done_pulses <= done_pulses + 1;
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: evaluate the edge list straight from the cost definitions
    task automatic model_eval(output int s, output int s1, output int mx, output bit eu, output bit er);
        s = 0; s1 = 0; mx = 0; eu = 0; er = 0;
        for (int e = 0; e < N_E; e++) begin
            int c [4];
            bit u, r;
            int dx, dy;
            c = '{px_mem[ea_mem[e]], py_mem[ea_mem[e]], px_mem[eb_mem[e]], py_mem[eb_mem[e]]};
            u = 0; r = 0;
            foreach (c[j]) begin
                if (c[j] == -1) u = 1;
                if (c[j] >= 12 || c[j] < -1) r = 1;
            end
            if (u || r) begin
                eu |= u;
                er |= r;
            end else begin
                dx = iabs(c[0] - c[2]);
                dy = iabs(c[1] - c[3]);
                s  += dx + dy - 1;
                s1 += (dx + 1) / 2 + (dy + 1) / 2 - 1;
                if (dx + dy > mx) mx = dx + dy;
            end
        end
    endtask

    function automatic int rand_coord(input int bad_pct);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < bad_pct) begin
            case ($urandom_range(0, 2))
                0:       return -1;
                1:       return 12 + int'($urandom_range(0, 8));
                default: return -2 - int'($urandom_range(0, 5));
            endcase
        end
        return int'($urandom_range(0, 11));
    endfunction

    task automatic fill_random(input int bad_pct);
        for (int n = 0; n < N_NODE; n++) begin
            px_mem[n] = rand_coord(bad_pct);
            py_mem[n] = rand_coord(bad_pct);
        end
        for (int e = 0; e < N_E; e++) begin
            ea_mem[e] = int'($urandom_range(0, N_NODE - 1));
            eb_mem[e] = int'($urandom_range(0, N_NODE - 1));
        end
    endtask

    task automatic set_node(input int n, input int x, input int y);
        px_mem[n] = x;
        py_mem[n] = y;
    endtask

    task automatic set_all_edges(input int a, input int b);
        for (int e = 0; e < N_E; e++) begin
            ea_mem[e] = a;
            eb_mem[e] = b;
        end
    endtask

    // Pulse start (cycle 0) and follow the run; optionally pulse start again in cycle extra_at
    task automatic run_eval(input int extra_at, output int done_cyc, output bit busy_ok);
        done_cyc = -1;
        busy_ok  = 1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= DONE_CYC + 100; k++) begin
            @(negedge clk);
            start = (k == extra_at);
            if (done) begin
                done_cyc = k;
                if (busy) busy_ok = 0;
                break;
            end
            if (!busy) busy_ok = 0;
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_values: outputs=%h required all zero", all_outs);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ea_re !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_reset: busy=%b ea_re=%b required 0 0", busy, ea_re);
        end
    endtask

    task automatic test_basic_edge;
        int dc, p0, x0, v0;
        bit bok;
        set_node(0, 0, 0);
        set_node(1, 3, 5);
        set_all_edges(0, 1);
        p0 = ea_pulses; x0 = px_pulses; v0 = re_viol;
        run_eval(0, dc, bok);
        n_checks++;
        if (dc !== DONE_CYC || !bok) begin
            n_fail++;
            $display("FAIL basic_timing: done_cycle=%0d busy_ok=%0b required %0d 1", dc, bok, DONE_CYC);
        end
        n_checks++;
        if (res_vec !== {32'sd994, 32'sd568, 32'd8, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_results: sum=%0d h=%0d max=%0d eu=%0b er=%0b required 994 568 8 0 0",
                     sum, sum_1hop, max_len, err_unplaced, err_range);
        end
        n_checks++;
        if (ea_pulses - p0 != N_E || px_pulses - x0 != 2 * N_E || re_viol != v0) begin
            n_fail++;
            $display("FAIL basic_strobes: ea=%0d px=%0d viol=%0d required %0d %0d 0",
                     ea_pulses - p0, px_pulses - x0, re_viol - v0, N_E, 2 * N_E);
        end
    endtask

    task automatic test_negative_diff;
        int dc;
        bit bok;
        set_node(0, 5, 2);
        set_node(1, 1, 7);
        set_all_edges(0, 1);
        run_eval(0, dc, bok);
        n_checks++;
        if (dc !== DONE_CYC || res_vec !== {32'sd1136, 32'sd568, 32'd9, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL negative_diff: done=%0d sum=%0d h=%0d max=%0d eu=%0b er=%0b required %0d 1136 568 9 0 0",
                     dc, sum, sum_1hop, max_len, err_unplaced, err_range, DONE_CYC);
        end
    endtask

    task automatic test_adjacent_self;
        int dc;
        bit bok;
        set_node(2, 2, 2);
        set_node(3, 2, 3);
        set_node(4, 4, 4);
        for (int e = 0; e < N_E; e++) begin
            ea_mem[e] = (e % 2 == 0) ? 2 : 4;
            eb_mem[e] = (e % 2 == 0) ? 3 : 4;
        end
        run_eval(0, dc, bok);
        n_checks++;
        if (res_vec !== {-32'sd71, -32'sd71, 32'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL adjacent_self: sum=%0d h=%0d max=%0d eu=%0b er=%0b required -71 -71 1 0 0",
                     sum, sum_1hop, max_len, err_unplaced, err_range);
        end
    endtask

    task automatic test_unplaced;
        int dc;
        bit bok;
        set_node(0, 0, 0);
        set_node(1, 3, 5);
        set_node(5, -1, 6);
        set_node(6, 5, 2);
        set_node(7, 1, 7);
        set_all_edges(5, 5);
        ea_mem[0] = 0; eb_mem[0] = 1;
        ea_mem[1] = 0; eb_mem[1] = 5;
        ea_mem[2] = 6; eb_mem[2] = 7;
        run_eval(0, dc, bok);
        n_checks++;
        if (res_vec !== {32'sd15, 32'sd8, 32'd9, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL unplaced: sum=%0d h=%0d max=%0d eu=%0b er=%0b required 15 8 9 1 0",
                     sum, sum_1hop, max_len, err_unplaced, err_range);
        end
    endtask

    task automatic test_range_restart;
        int dc;
        bit bok;
        set_node(0, 0, 0);
        set_node(1, 3, 5);
        set_node(8, 12, 0);
        set_all_edges(0, 8);
        ea_mem[0] = 8; eb_mem[0] = 0;
        ea_mem[1] = 0; eb_mem[1] = 1;
        run_eval(0, dc, bok);
        n_checks++;
        if (res_vec !== {32'sd7, 32'sd4, 32'd8, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL range: sum=%0d h=%0d max=%0d eu=%0b er=%0b required 7 4 8 0 1",
                     sum, sum_1hop, max_len, err_unplaced, err_range);
        end
        set_all_edges(0, 1);
        run_eval(300, dc, bok);
        n_checks++;
        if (dc !== DONE_CYC || !bok) begin
            n_fail++;
            $display("FAIL start_while_busy: done_cycle=%0d busy_ok=%0b required %0d 1", dc, bok, DONE_CYC);
        end
        n_checks++;
        if (res_vec !== {32'sd994, 32'sd568, 32'd8, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL range_cleared: sum=%0d h=%0d max=%0d eu=%0b er=%0b required 994 568 8 0 0",
                     sum, sum_1hop, max_len, err_unplaced, err_range);
        end
    endtask

    task automatic test_random;
        int dc, es, es1, emx;
        bit bok, eu, er;
        for (int it = 0; it < 4; it++) begin
            fill_random(8);
            model_eval(es, es1, emx, eu, er);
            run_eval(0, dc, bok);
            n_checks++;
            if (dc !== DONE_CYC || res_vec !== {es, es1, emx, eu, er}) begin
                n_fail++;
                $display("FAIL random_%0d: done=%0d sum=%0d h=%0d max=%0d eu=%0b er=%0b required %0d %0d %0d %0d %0b %0b",
                         it, dc, sum, sum_1hop, max_len, err_unplaced, err_range, DONE_CYC, es, es1, emx, eu, er);
            end
        end
    endtask

    task automatic test_reset_mid;
        int dc, es, es1, emx, d0, p0, x0, v0;
        bit bok, eu, er, idle_ok;
        fill_random(12);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 500; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_values: outputs=%h required all zero", all_outs);
        end
        reset = 1'b0;
        d0 = done_pulses;
        idle_ok = 1;
        repeat (DONE_CYC + 50) begin
            @(negedge clk);
            if (busy) idle_ok = 0;
        end
        n_checks++;
        if (done_pulses != d0 || !idle_ok) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: done_pulses=%0d idle=%0b required 0 1", done_pulses - d0, idle_ok);
        end
        model_eval(es, es1, emx, eu, er);
        p0 = ea_pulses; x0 = px_pulses; v0 = re_viol;
        run_eval(0, dc, bok);
        n_checks++;
        if (dc !== DONE_CYC || !bok || res_vec !== {es, es1, emx, eu, er}) begin
            n_fail++;
            $display("FAIL reset_mid_restart: done=%0d busy_ok=%0b sum=%0d h=%0d max=%0d eu=%0b er=%0b required %0d 1 %0d %0d %0d %0b %0b",
                     dc, bok, sum, sum_1hop, max_len, err_unplaced, err_range, DONE_CYC, es, es1, emx, eu, er);
        end
        n_checks++;
        if (ea_pulses - p0 != N_E || px_pulses - x0 != 2 * N_E || re_viol != v0) begin
            n_fail++;
            $display("FAIL restart_strobes: ea=%0d px=%0d viol=%0d required %0d %0d 0",
                     ea_pulses - p0, px_pulses - x0, re_viol - v0, N_E, 2 * N_E);
        end
    endtask

    task automatic test_back_to_back;
        int dc, es, es1, emx;
        bit bok, eu, er, idle_ok;
        fill_random(5);
        model_eval(es, es1, emx, eu, er);
        run_eval(DONE_CYC, dc, bok);
        idle_ok = 1;
        repeat (3) begin
            @(negedge clk);
            if (busy) idle_ok = 0;
        end
        n_checks++;
        if (!idle_ok || res_vec !== {es, es1, emx, eu, er}) begin
            n_fail++;
            $display("FAIL start_in_done: idle=%0b sum=%0d required idle 1 sum %0d", idle_ok, sum, es);
        end
        fill_random(5);
        model_eval(es, es1, emx, eu, er);
        run_eval(0, dc, bok);
        n_checks++;
        if (dc !== DONE_CYC || !bok || res_vec !== {es, es1, emx, eu, er}) begin
            n_fail++;
            $display("FAIL back_to_back: done=%0d sum=%0d h=%0d max=%0d required %0d %0d %0d %0d",
                     dc, sum, sum_1hop, max_len, DONE_CYC, es, es1, emx);
        end
    endtask

    initial begin
        for (int n = 0; n < N_NODE; n++) set_node(n, 0, 0);
        set_all_edges(0, 0);
        test_reset();
        test_basic_edge();
        test_negative_diff();
        test_adjacent_self();
        test_unplaced();
        test_range_restart();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
